// File: rtl/sequence_detector_ctrl.sv
// -----------------------------------------------------------------------------
// sequence_detector_ctrl
//
// Word-to-bit sequence detector controller. Parallel words arrive over a
// valid/ready handshake and are serialised LSB-first into a SEQ_LEN-bit
// sliding window. Each shift compares the updated window against a
// programmable pattern/mask. Matches are counted (saturating), and a sticky
// interrupt is raised when the count reaches a programmable threshold.
//
// Optional build macro:
//   SEQ_DET_CLEAR_ON_START_EN - when defined, start in IDLE also clears the
//                               window, fill level and match count. irq is
//                               left untouched. Default: history carries over.
//
// Ports:
//   clk           in   clock, rising-edge
//   reset         in   asynchronous reset, active low
//   cfg_we        in   config write strobe (IDLE only)
//   cfg_pattern   in   [SEQ_LEN]  pattern to match
//   cfg_mask      in   [SEQ_LEN]  1 = bit compared, 0 = don't care
//   cfg_threshold in   [CNT_W]    match count that raises irq, 0 = never
//   start         in   IDLE -> WAIT
//   stop          in   return to IDLE (never truncates a word)
//   in_valid      in   producer word valid
//   in_data       in   [WORD_W]   producer word
//   in_ready      out  high only in WAIT
//   busy          out  high in WAIT and SHIFT
//   data_out      out  one-cycle match pulse aligned with shift_regs
//   shift_regs    out  [SEQ_LEN]  current window, bit 0 = newest
//   match_count   out  [CNT_W]    saturating match count
//   irq           out  sticky threshold interrupt
//   irq_clr       in   clears irq (a coincident set wins)
// -----------------------------------------------------------------------------
module sequence_detector_ctrl #(
  parameter int WORD_W  = 8,
  parameter int SEQ_LEN = 7,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [SEQ_LEN-1:0] cfg_pattern,
  input  logic [SEQ_LEN-1:0] cfg_mask,
  input  logic [CNT_W-1:0]   cfg_threshold,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               data_out,
  output logic [SEQ_LEN-1:0] shift_regs,
  output logic [CNT_W-1:0]   match_count,
  output logic               irq,
  input  logic               irq_clr
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(SEQ_LEN + 1);

  localparam logic [IDX_W-1:0]   IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0]  FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0]  FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [SEQ_LEN-1:0] WIN_ZERO  = {SEQ_LEN{1'b0}};
  localparam logic [WORD_W-1:0]  WORD_ZERO = {WORD_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Masked compare: only bits with mask=1 must equal the pattern.
  function automatic logic window_match(
    input logic [SEQ_LEN-1:0] window,
    input logic [SEQ_LEN-1:0] pattern,
    input logic [SEQ_LEN-1:0] mask
  );
    return (((window ^ pattern) & mask) == {SEQ_LEN{1'b0}});
  endfunction

  state_t              state_r;
  logic [WORD_W-1:0]   word_r;
  logic [IDX_W-1:0]    bit_idx_r;
  logic                stop_seen_r;
  logic [FILL_W-1:0]   fill_r;
  logic [SEQ_LEN-1:0]  pattern_r;
  logic [SEQ_LEN-1:0]  mask_r;
  logic [CNT_W-1:0]    threshold_r;

  logic                shift_bit_s;
  logic [SEQ_LEN-1:0]  window_next_s;
  logic [FILL_W-1:0]   fill_next_s;
  logic                match_s;
  logic                count_step_s;
  logic [CNT_W-1:0]    count_next_s;
  logic                thr_hit_s;

  // Next-window, fill, match and counter values for the current shift cycle.
  always_comb begin
    shift_bit_s   = word_r[bit_idx_r];
    window_next_s = {shift_regs[SEQ_LEN-2:0], shift_bit_s};

    if (fill_r == FILL_FULL) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + FILL_ONE;
    end

    // A match is only valid once the window holds SEQ_LEN real bits.
    match_s = (fill_next_s == FILL_FULL) &&
              window_match(window_next_s, pattern_r, mask_r);

    if (match_s && (match_count != CNT_MAX)) begin
      count_step_s = 1'b1;
      count_next_s = match_count + CNT_ONE;
    end else begin
      count_step_s = 1'b0;
      count_next_s = match_count;
    end

    // irq fires only on the edge where the count actually moves onto the
    // threshold, so a saturated or stalled count never re-triggers it.
    thr_hit_s = count_step_s && (threshold_r != CNT_ZERO) &&
                (count_next_s == threshold_r);
  end

  // Controller FSM with all outputs and detector state registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      word_r      <= WORD_ZERO;
      bit_idx_r   <= IDX_ZERO;
      stop_seen_r <= 1'b0;
      fill_r      <= FILL_ZERO;
      pattern_r   <= WIN_ZERO;
      mask_r      <= WIN_ZERO;
      threshold_r <= CNT_ZERO;
      shift_regs  <= WIN_ZERO;
      match_count <= CNT_ZERO;
      data_out    <= 1'b0;
      irq         <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // data_out is a pulse: only a shift edge can raise it.
      data_out <= 1'b0;

      // Clear first; a set later in this block overrides it (set wins).
      if (irq_clr) begin
        irq <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (cfg_we) begin
            pattern_r   <= cfg_pattern;
            mask_r      <= cfg_mask;
            threshold_r <= cfg_threshold;
          end
          if (start) begin
            state_r  <= ST_WAIT;
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef SEQ_DET_CLEAR_ON_START_EN
            shift_regs  <= WIN_ZERO;
            fill_r      <= FILL_ZERO;
            match_count <= CNT_ZERO;
`endif
          end
        end

        ST_WAIT: begin
          // in_ready is high throughout WAIT, so in_valid is the handshake.
          if (in_valid) begin
            word_r      <= in_data;
            bit_idx_r   <= IDX_ZERO;
            stop_seen_r <= stop;
            state_r     <= ST_SHIFT;
            in_ready    <= 1'b0;
          end else if (stop) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        end

        ST_SHIFT: begin
          shift_regs  <= window_next_s;
          fill_r      <= fill_next_s;
          match_count <= count_next_s;
          data_out    <= match_s;
          stop_seen_r <= stop_seen_r | stop;
          if (thr_hit_s) begin
            irq <= 1'b1;
          end

          if (bit_idx_r == LAST_IDX) begin
            // A stop seen anywhere in the word takes effect only here.
            if (stop_seen_r || stop) begin
              state_r  <= ST_IDLE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              state_r  <= ST_WAIT;
              in_ready <= 1'b1;
            end
          end else begin
            bit_idx_r <= bit_idx_r + IDX_ONE;
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sequence_detector_ctrl.md
Name: sequence_detector_ctrl

Overview:
Controller around a programmable shift-register sequence detector. Accepts parallel words over a valid/ready handshake and serialises them LSB-first into a SEQ_LEN-bit window. Compares the window against a configured pattern/mask, counts matches, and raises a sticky interrupt at a programmable threshold. Sits between a word-oriented producer and the detector result/interrupt logic.

Parameters:
WORD_W, 8, input word width (bits serialised per word)
SEQ_LEN, 7, shift window length
CNT_W, 8, match counter and threshold width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; asserted when 0
cfg_we  input  1  config write strobe; honoured only in IDLE
cfg_pattern  input  SEQ_LEN  pattern to match
cfg_mask  input  SEQ_LEN  1 = bit compared, 0 = don't care
cfg_threshold  input  CNT_W  match count that sets irq; 0 disables irq
start  input  1  IDLE -> WAIT
stop  input  1  request return to IDLE
in_valid  input  1  producer word valid
in_data  input  WORD_W  producer word
in_ready  output  1  high only in WAIT
busy  output  1  high in WAIT and SHIFT
data_out  output  1  registered match pulse
shift_regs  output  SEQ_LEN  current window; bit 0 = newest bit
match_count  output  CNT_W  saturating match count
irq  output  1  sticky threshold interrupt
irq_clr  input  1  clears irq

Behaviour:
- Reset (reset=0, async): state IDLE; shift_regs=0, fill=0, match_count=0, data_out=0, irq=0, config registers pattern=0, mask=0, threshold=0; in_ready=0, busy=0.
- FSM: IDLE, WAIT, SHIFT.
- IDLE: cfg_we latches pattern/mask/threshold. start -> WAIT. cfg_we outside IDLE is ignored. If cfg_we and start are both high, config is latched and the state moves to WAIT.
- WAIT: in_ready=1. An in_valid&&in_ready edge latches in_data into the word buffer, clears bit index, -> SHIFT. stop with no handshake -> IDLE. If stop and the handshake coincide, the word is accepted and stop is remembered.
- SHIFT: one bit per cycle, in_data[0] first. shift_regs <= {shift_regs[SEQ_LEN-2:0], bit}. fill increments, saturating at SEQ_LEN. After WORD_W shifts -> WAIT, or -> IDLE if stop was seen at any point during the word. stop never truncates a word. This gives one bubble cycle (WAIT) between back-to-back words.
- Match: computed on the next window value. match = (fill_next == SEQ_LEN) && (((window_next ^ pattern) & mask) == 0). Overlapping matches all count. data_out <= match on every shift edge and 0 on non-shift edges, so it is a 1-cycle pulse aligned with the updated shift_regs.
- match_count increments on each match and saturates at all-ones.
- irq sets on the edge where match_count becomes equal to threshold (threshold != 0). It stays set until irq_clr. If set and clear coincide, set wins.
- shift_regs, fill and match_count persist across IDLE/start unless the optional feature is enabled.
- Async reset mid-word: the word is discarded, all state returns to reset values, and no data_out pulse is produced.

Optional Feature:
SEQ_DET_CLEAR_ON_START_EN
- Defined: start in IDLE also clears shift_regs, fill and match_count to 0 on the same edge. irq is unaffected.
- Undefined: start only changes state; detector history and count carry over between runs.

Test Plan:
- Reset while busy: assert reset=0 mid-SHIFT -> all outputs 0 immediately, state IDLE, in_ready=0.
- Basic detect: cfg pattern=7'b0000101, mask=7'b0000111, threshold=0; start; send 8'h55 -> single data_out pulse on the 7th shift. Then 8'h55 -> 4 pulses on shifts 1,3,5,7. match_count=5, irq=0.
- Threshold irq: same config with threshold=3, words 8'h55, 8'h55 -> irq rises on the edge match_count goes 2->3 and stays high. irq_clr together with a further match that does not hit threshold -> irq clears. Clear coinciding with a set -> irq stays 1.
- Fill gating: mask=0, pattern=0, send 8'h00 -> no pulse on shifts 1-6, then pulses on shifts 7 and 8. match_count=2.
- Handshake/stop: in_valid held high -> in_ready high exactly 1 cycle per word, 9 cycles per word. stop asserted on shift 3 -> word completes all 8 shifts, then IDLE. cfg_we during SHIFT -> pattern unchanged.
- Saturation/feature: CNT_W=8, mask=0, stream 40 words -> match_count stops at 255. With SEQ_DET_CLEAR_ON_START_EN defined, stop then start -> match_count=0 and shift_regs=0. Undefined -> values retained.
